// File: rtl/neuron_top.sv
// ============================================================================
// Module   : neuron_top
// Brief    : Single-neuron dot product to saturated sigmoid-LUT address, 3-stage pipeline.
//            Optional macro NEURON_TOP_ROUND_EN: round-half-up before the Q.8 rescale.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_top #(
  parameter int MAX_NEURONS = 10,
  parameter int WEIGHT_SIZE = 17,
  parameter int INPUT_SIZE  = 9,
  parameter int FRACTION    = 8,
  parameter int ADDR_SIZE   = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [$clog2(MAX_NEURONS)-1:0]     input_signals,
  input  logic [MAX_NEURONS*WEIGHT_SIZE-1:0] weights,
  input  logic [MAX_NEURONS*INPUT_SIZE-1:0]  inputs,
  output logic [ADDR_SIZE-1:0]               addr,
  output logic                               lut_valid
);

  localparam int PROD_W = WEIGHT_SIZE + INPUT_SIZE;
  localparam int SUM_W  = PROD_W + $clog2(MAX_NEURONS);

  localparam logic signed [SUM_W-1:0] C_ADDR_MAX = SUM_W'((2 ** (ADDR_SIZE - 1)) - 1);
  localparam logic signed [SUM_W-1:0] C_ADDR_MIN = -SUM_W'(2 ** (ADDR_SIZE - 1));
`ifdef NEURON_TOP_ROUND_EN
  localparam logic signed [SUM_W-1:0] C_ROUND    = SUM_W'(2 ** (FRACTION - 1));
`else
  localparam logic signed [SUM_W-1:0] C_ROUND    = '0;
`endif

  logic signed [PROD_W-1:0] w_prod [MAX_NEURONS];
  logic signed [PROD_W-1:0] r_prod [MAX_NEURONS];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  r_sum;
  logic signed [SUM_W-1:0]  w_scaled;
  logic [ADDR_SIZE-1:0]     w_addr;
  logic                     r_v1;
  logic                     r_v2;

  // Counts above MAX_NEURONS need no explicit clamp: every lane index is below them.
  generate
    for (genvar gi = 0; gi < MAX_NEURONS; gi++) begin : g_lane
      localparam logic [31:0] c_lane_idx = gi;
      logic signed [WEIGHT_SIZE-1:0] w_wt;
      logic signed [INPUT_SIZE-1:0]  w_in;
      logic signed [PROD_W-1:0]      w_mul;
      logic                          w_active;

      assign w_wt       = weights[gi*WEIGHT_SIZE +: WEIGHT_SIZE];
      assign w_in       = inputs[gi*INPUT_SIZE +: INPUT_SIZE];
      assign w_mul      = PROD_W'(w_wt) * PROD_W'(w_in);
      assign w_active   = (c_lane_idx < 32'(input_signals));
      assign w_prod[gi] = w_active ? w_mul : '0;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < MAX_NEURONS; i++) begin
      w_sum = w_sum + SUM_W'(r_prod[i]);
    end
  end

  // Arithmetic shift floors toward minus infinity; the optional bias turns it into round-half-up.
  assign w_scaled = (r_sum + C_ROUND) >>> FRACTION;

  always_comb begin
    w_addr = '0;
    if (w_scaled > C_ADDR_MAX) begin
      w_addr = '1;
    end else if (w_scaled < C_ADDR_MIN) begin
      w_addr = '0;
    end else begin
      w_addr = ADDR_SIZE'(w_scaled - C_ADDR_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < MAX_NEURONS; i++) begin
        r_prod[i] <= '0;
      end
    end else begin
      r_v1 <= enable;
      if (enable) begin
        for (int i = 0; i < MAX_NEURONS; i++) begin
          r_prod[i] <= w_prod[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_sum <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum <= w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_valid <= 1'b0;
      addr      <= '0;
    end else begin
      lut_valid <= r_v2;
      if (r_v2) begin
        addr <= w_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_top.sv
// ============================================================================
// Module   : tb_neuron_top
// Brief    : Randomised and directed self-checking bench for neuron_top.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_neuron_top;

  localparam int N  = 10;
  localparam int WS = 17;
  localparam int XS = 9;
  localparam int FR = 8;
  localparam int AS = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [3:0]      input_signals;
  logic [N*WS-1:0] weights;
  logic [N*XS-1:0] inputs;
  logic [AS-1:0]   addr;
  logic            lut_valid;

  int checks   = 0;
  int failures = 0;

  int w_t [N];
  int x_t [N];

  typedef struct {
    bit v;
    int a;
  } ent_t;

  ent_t pipe[$];
  int   m_addr  = 0;
  bit   m_valid = 1'b0;

`ifdef NEURON_TOP_ROUND_EN
  localparam int TP1_ADDR = 180;
`else
  localparam int TP1_ADDR = 179;
`endif

  neuron_top dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .input_signals (input_signals),
    .weights       (weights),
    .inputs        (inputs),
    .addr          (addr),
    .lut_valid     (lut_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer dot product, floor or round-half-up divide by 256, clamp to LUT domain.
  function automatic int ref_addr(input int n);
    longint s = 0;
    int     k = (n > N) ? N : n;
    for (int i = 0; i < k; i++) begin
      s += longint'(w_t[i]) * longint'(x_t[i]);
    end
`ifdef NEURON_TOP_ROUND_EN
    s += 128;
`endif
    s = s >>> FR;
    if (s > 511) return 1023;
    if (s < -512) return 0;
    return int'(s) + 512;
  endfunction

  // One clock: drive at negedge, advance model on the posedge, compare at the next negedge.
  task automatic cycle(input bit en, input bit r, input int n);
    ent_t e_new;
    ent_t e_out;
    int   wv;
    int   xv;
    enable        = en;
    rst           = r;
    input_signals = 4'(n);
    for (int i = 0; i < N; i++) begin
      wv = w_t[i];
      xv = x_t[i];
      weights[i*WS +: WS] = wv[WS-1:0];
      inputs[i*XS +: XS]  = xv[XS-1:0];
    end
    @(posedge clk);
    e_new.v = en && !r;
    e_new.a = ref_addr(n);
    if (r) begin
      pipe.delete();
      pipe.push_back('{1'b0, 0});
      pipe.push_back('{1'b0, 0});
      m_addr  = 0;
      m_valid = 1'b0;
    end else begin
      e_out   = pipe.pop_front();
      m_valid = e_out.v;
      if (e_out.v) m_addr = e_out.a;
      pipe.push_back(e_new);
    end
    @(negedge clk);
    check("lut_valid", longint'(lut_valid), longint'(m_valid));
    check("addr", longint'(addr), longint'(m_addr));
  endtask

  task automatic junk_lanes(input int from);
    for (int i = from; i < N; i++) begin
      w_t[i] = int'($urandom_range(1, 131071)) - 65536;
      x_t[i] = int'($urandom_range(1, 511)) - 256;
      if (w_t[i] == 0) w_t[i] = 3;
      if (x_t[i] == 0) x_t[i] = 5;
    end
  endtask

  // Present one operand set, then two idle cycles so the result is at the output.
  task automatic run_one(input int n);
    cycle(1'b1, 1'b0, n);
    cycle(1'b0, 1'b0, n);
    cycle(1'b0, 1'b0, n);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      w_t[i] = 0;
      x_t[i] = 0;
    end
    @(negedge clk);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b1, 1'b1, 4);
    check("reset_addr", longint'(addr), 0);
    check("reset_valid", longint'(lut_valid), 0);

    // Mixed-sign four-lane product
    junk_lanes(4);
    w_t[0] = 512;   x_t[0] = 128;
    w_t[1] = 50;    x_t[1] = -64;
    w_t[2] = -7;    x_t[2] = -12;
    w_t[3] = -1024; x_t[3] = 144;
    run_one(4);
    check("tp1_addr", longint'(addr), TP1_ADDR);
    check("tp1_valid", longint'(lut_valid), 1);

    // Saturation at both ends
    w_t[0] = -5439; x_t[0] = 58;
    w_t[1] = -12;   x_t[1] = -213;
    run_one(2);
    check("tp2_negsat", longint'(addr), 0);
    w_t[0] = 5439;
    w_t[1] = 12;
    run_one(2);
    check("tp3_possat", longint'(addr), 1023);

    // All lanes, then only two lanes with junk above
    for (int j = 0; j < N; j++) begin
      w_t[j] = 10;
      x_t[j] = j + 1;
    end
    run_one(10);
    check("tp4_all_lanes", longint'(addr), 514);
    junk_lanes(2);
    run_one(2);
    check("tp4_masked", longint'(addr), 512);

    // Long idle gap holds the address
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 2);
    check("tp5_hold", longint'(addr), 512);
    check("tp5_idle_valid", longint'(lut_valid), 0);
    junk_lanes(0);
    run_one(0);
    check("tp5_zero_lanes", longint'(addr), 512);

    // Reset right after an enable pulse kills the in-flight result
    run_one(3);
    cycle(1'b1, 1'b0, 7);
    cycle(1'b0, 1'b1, 7);
    check("tp6_rst_addr", longint'(addr), 0);
    check("tp6_rst_valid", longint'(lut_valid), 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 7);
      check("tp6_no_stale", longint'(lut_valid), 0);
    end

    // Back-to-back results
    for (int k = 0; k < 6; k++) begin
      junk_lanes(0);
      cycle(1'b1, 1'b0, int'($urandom_range(0, 15)));
    end

    // Random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      junk_lanes(0);
      if ($urandom_range(0, 3) == 0) begin
        w_t[0] = ($urandom_range(0, 1) == 1) ? 65535 : -65536;
        x_t[0] = ($urandom_range(0, 1) == 1) ? 255 : -256;
      end
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
